// File: rtl/store_data_aligner.sv
// Store data aligner: narrows MEM-stage store data to byte/half/word, replicates it onto
// the byte lanes, builds byte enables, flags misaligned or illegal-size requests, and
// queues good stores in a small circular FIFO that drains to data memory.
// Latency: a store accepted at edge N is presented on mem_* in cycle N+1 (registered, no pass-through).
// Backpressure: st_ready drops when the queue is full or flush is high; the head is held while mem_wr_ready is low.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            synchronous queue flush (empties the queue on this edge)
//   st_valid/ready   store request handshake; st_addr, st_data, st_size describe the store
//   mem_wr_valid/rdy write handshake to data memory; mem_addr, mem_wdata, mem_be carry the head entry
//   addr_err         one-cycle pulse after a faulting request was consumed; err_addr holds its address
//   count            number of occupied queue entries
module store_data_aligner #(
    parameter int DEPTH      = 2,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     mem_wr_valid,
    input  logic                     mem_wr_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     addr_err,
    output logic [31:0]              err_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // ------------------------------------------------------------------
    // Queue storage and control state
    // ------------------------------------------------------------------
    logic [31:0]   ent_addr_q  [DEPTH];
    logic [31:0]   ent_wdata_q [DEPTH];
    logic [3:0]    ent_be_q    [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Registered copy of the head entry; it only reloads when the queue will be
    // non-empty, so the last values remain visible while the queue is empty.
    logic [31:0]   out_addr_q,  out_addr_d;
    logic [31:0]   out_wdata_q, out_wdata_d;
    logic [3:0]    out_be_q,    out_be_d;

    logic          err_pulse_q, err_pulse_d;
    logic [31:0]   err_addr_q,  err_addr_d;

    // ------------------------------------------------------------------
    // Packing and alignment check of the incoming request
    // ------------------------------------------------------------------
    logic [1:0]    lane;
    logic [31:0]   pk_addr;
    logic [31:0]   pk_wdata;
    logic [3:0]    pk_be;
    logic          pk_fault;

    always_comb begin
        lane     = st_addr[1:0];
        pk_addr  = {st_addr[31:2], 2'b00};
        pk_wdata = st_data;
        pk_be    = 4'b0000;
        pk_fault = 1'b0;
        unique case (st_size)
            2'b00: begin
                pk_wdata = {4{st_data[7:0]}};
                pk_be    = BIG_ENDIAN ? (4'b1000 >> lane) : (4'b0001 << lane);
            end
            2'b01: begin
                pk_wdata = {2{st_data[15:0]}};
                if (BIG_ENDIAN) begin
                    pk_be = lane[1] ? 4'b0011 : 4'b1100;
                end else begin
                    pk_be = lane[1] ? 4'b1100 : 4'b0011;
                end
                pk_fault = lane[0];
            end
            2'b10: begin
                pk_be    = 4'b1111;
                pk_fault = (lane != 2'b00);
            end
            default: begin
                pk_fault = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes and next-state
    // ------------------------------------------------------------------
    logic          full;
    logic          accept;
    logic          enq;
    logic          deq;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx_d;
    logic          bypass;

    assign full     = (count_q == CW'(DEPTH));
    // A dequeue in the same cycle does not open a slot: ready depends on registered state only.
    assign st_ready = ~full & ~flush;
    assign accept   = st_valid & st_ready;
    assign enq      = accept & ~pk_fault;
    assign deq      = (count_q != '0) & mem_wr_ready;
    assign wr_idx   = wr_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_pulse_d = accept & pk_fault;
        err_addr_d  = (accept & pk_fault) ? st_addr : err_addr_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // The next head is the incoming store when it is written into the slot the
    // read pointer will point at (queue empty, or one entry draining while
    // another arrives); otherwise it is already in storage.
    assign rd_idx_d = rd_ptr_d[AW-1:0];
    assign bypass   = enq & (wr_idx == rd_idx_d);

    always_comb begin
        out_addr_d  = out_addr_q;
        out_wdata_d = out_wdata_q;
        out_be_d    = out_be_q;
        if (count_d != '0) begin
            if (bypass) begin
                out_addr_d  = pk_addr;
                out_wdata_d = pk_wdata;
                out_be_d    = pk_be;
            end else begin
                out_addr_d  = ent_addr_q[rd_idx_d];
                out_wdata_d = ent_wdata_q[rd_idx_d];
                out_be_d    = ent_be_q[rd_idx_d];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_addr_q  <= '0;
            out_wdata_q <= '0;
            out_be_q    <= '0;
            err_pulse_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_addr_q  <= out_addr_d;
            out_wdata_q <= out_wdata_d;
            out_be_q    <= out_be_d;
            err_pulse_q <= err_pulse_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i]  <= '0;
                ent_wdata_q[i] <= '0;
                ent_be_q[i]    <= '0;
            end
        end else if (enq) begin
            ent_addr_q[wr_idx]  <= pk_addr;
            ent_wdata_q[wr_idx] <= pk_wdata;
            ent_be_q[wr_idx]    <= pk_be;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_wr_valid = (count_q != '0);
    assign mem_addr     = out_addr_q;
    assign mem_wdata    = out_wdata_q;
    assign mem_be       = out_be_q;
    assign addr_err     = err_pulse_q;
    assign err_addr     = err_addr_q;
    assign count        = count_q;

endmodule
